// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at accept, held internally, and written to HI/LO after a fixed latency.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  logic            accept, is_md, is_signed, a_neg, b_neg;
  logic [63:0]     prod;
  logic [31:0]     a_mag, b_mag, quo_mag, rem_mag, div_q, div_r;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // Signed divide works on magnitudes so 0x80000000 / -1 needs no overflow special case.
  always_comb begin
    is_signed = ~Op[0];
    a_neg     = is_signed & D1[31];
    b_neg     = is_signed & D2[31];
    a_mag     = a_neg ? (32'd0 - D1) : D1;
    b_mag     = b_neg ? (32'd0 - D2) : D2;
    quo_mag   = '0;
    rem_mag   = '0;
    if (b_mag != '0) begin
      quo_mag = a_mag / b_mag;
      rem_mag = a_mag % b_mag;
    end
    div_q = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    div_r = a_neg ? (32'd0 - rem_mag) : rem_mag;
    if (b_mag == '0) begin
      div_q = '1;
      div_r = D1;
    end
    if (is_signed) prod = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
    else           prod = {32'd0, D1} * {32'd0, D2};
  end

  always_comb begin
    accept   = Start & ~Flush & (state_q == S_IDLE);
    is_md    = accept & (Op <= 3'd3);
    state_d  = state_q;
    count_d  = count_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      S_IDLE: begin
        if (is_md) begin
          state_d  = S_BUSY;
          count_d  = Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          res_hi_d = Op[1] ? div_r : prod[63:32];
          res_lo_d = Op[1] ? div_q : prod[31:0];
        end
      end
      S_BUSY: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_BUSY && count_q == CW'(1)) begin
      hi_d = res_hi_q;
      lo_d = res_lo_q;
    end else if (accept && Op == 3'd4) begin
      hi_d = D1;
    end else if (accept && Op == 3'd5) begin
      lo_d = D1;
    end
  end

  always_comb begin
    Busy = (state_q == S_BUSY);
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule
